game_flow_ctl: RTL

Match sequencer for the PONG display path. It decodes menu clicks and the board button, paces serve and game-over delays in video frames, and keeps the score. It drives the screen-select code that chooses between the menu, game and credits renderers, plus the enable and reset controls of the ball/paddle datapath. It sits between the mouse/button inputs and the screen multiplexer, clocked by the pixel clock.

---
 rtl/game_flow_ctl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/game_flow_ctl.sv
// PONG match sequencer: menu/credits navigation, frame-paced serve and game-over delays,
// score keeping. Every output is registered and decoded from the next state.
module game_flow_ctl #(
    parameter int unsigned WIN_SCORE    = 5,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned OVER_FRAMES  = 180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vsync_in,
    input  logic        mouse_left,
    input  logic        button,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        miss_left,
    input  logic        miss_right,
    output logic [1:0]  screen,
    output logic        ball_en,
    output logic        ball_rst,
    output logic [3:0]  score_l,
    output logic [3:0]  score_r,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {StMenu, StCredits, StServe, StPlay, StOver} state_e;

    localparam logic [1:0] ScrMenu    = 2'b00;
    localparam logic [1:0] ScrGame    = 2'b01;
    localparam logic [1:0] ScrCredits = 2'b10;
    localparam logic [3:0] WinLim     = 4'(WIN_SCORE);
    localparam logic [7:0] ServeLim   = 8'(SERVE_FRAMES);
    localparam logic [7:0] OverLim    = 8'(OVER_FRAMES);

    state_e      state_q, state_d;
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic [3:0]  score_l_q, score_l_d;
    logic [3:0]  score_r_q, score_r_d;
    logic [1:0]  winner_q, winner_d;
    logic [1:0]  screen_q, screen_d;
    logic        ball_en_q, ball_en_d;
    logic        ball_rst_q, ball_rst_d;
    logic        mouse_q, button_q, vsync_q;

    logic click, press, tick;
    logic in_start, in_credits;

    assign click = mouse_left & ~mouse_q;
    assign press = button & ~button_q;
    assign tick  = vsync_in & ~vsync_q;

    assign in_start   = (xpos >= 12'd362) && (xpos <= 12'd674) &&
                        (ypos >= 12'd46)  && (ypos <= 12'd146);
    assign in_credits = (xpos >= 12'd362) && (xpos <= 12'd674) &&
                        (ypos >= 12'd622) && (ypos <= 12'd722);

    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        winner_d  = winner_q;

        unique case (state_q)
            StMenu: begin
                if (click && in_start) begin
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    winner_d  = 2'b00;
                    state_d   = StServe;
                end else if (click && in_credits) begin
                    state_d = StCredits;
                end
            end
            StCredits: begin
                if (press) state_d = StMenu;
            end
            StServe: begin
                if (press) begin
                    state_d = StMenu;
                end else if (frame_cnt_q >= ServeLim) begin
                    state_d = StPlay;
                end
            end
            StPlay: begin
                // Press wins over any miss pulse in the same cycle.
                if (press) begin
                    state_d = StMenu;
                end else if (miss_left && miss_right) begin
                    state_d = StServe;
                end else if (miss_right) begin
                    score_l_d = score_l_q + 4'd1;
                    if (score_l_d == WinLim) begin
                        winner_d = 2'b01;
                        state_d  = StOver;
                    end else begin
                        state_d = StServe;
                    end
                end else if (miss_left) begin
                    score_r_d = score_r_q + 4'd1;
                    if (score_r_d == WinLim) begin
                        winner_d = 2'b10;
                        state_d  = StOver;
                    end else begin
                        state_d = StServe;
                    end
                end
            end
            StOver: begin
                if (press || (frame_cnt_q >= OverLim)) state_d = StMenu;
            end
            default: state_d = StMenu;
        endcase

        frame_cnt_d = frame_cnt_q;
        if (state_d != state_q) begin
            frame_cnt_d = 8'd0;
        end else if (tick && ((state_q == StServe) || (state_q == StOver)) &&
                     (frame_cnt_q != 8'hFF)) begin
            frame_cnt_d = frame_cnt_q + 8'd1;
        end

        // Outputs follow the state being entered so they update with the state register.
        screen_d   = ScrGame;
        ball_en_d  = 1'b0;
        ball_rst_d = 1'b1;
        unique case (state_d)
            StMenu:    screen_d = ScrMenu;
            StCredits: screen_d = ScrCredits;
            StPlay: begin
                ball_en_d  = 1'b1;
                ball_rst_d = 1'b0;
            end
            default: screen_d = ScrGame;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StMenu;
            frame_cnt_q <= 8'd0;
            score_l_q   <= 4'd0;
            score_r_q   <= 4'd0;
            winner_q    <= 2'b00;
            screen_q    <= ScrMenu;
            ball_en_q   <= 1'b0;
            ball_rst_q  <= 1'b1;
            mouse_q     <= 1'b0;
            button_q    <= 1'b0;
            vsync_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            winner_q    <= winner_d;
            screen_q    <= screen_d;
            ball_en_q   <= ball_en_d;
            ball_rst_q  <= ball_rst_d;
            mouse_q     <= mouse_left;
            button_q    <= button;
            vsync_q     <= vsync_in;
        end
    end

    assign screen   = screen_q;
    assign ball_en  = ball_en_q;
    assign ball_rst = ball_rst_q;
    assign score_l  = score_l_q;
    assign score_r  = score_r_q;
    assign winner   = winner_q;

endmodule
